key_conditioner: RTL

Input-conditioning stage between the board push-buttons and the rest of the robot design. It synchronises the raw active-low `KEY` pins into `clock_50` and debounces each key independently. It produces a clean pressed level plus one-cycle press, release and auto-repeat pulses. `world`, and any later command logic, consume these pulses instead of raw pins, so a single physical press yields exactly one robot command.

---
 rtl/robot_pkg.sv | 20 ++
 rtl/key_channel.sv | 106 ++++++++++
 rtl/key_conditioner.sv | 35 +++
 3 files changed

// File: rtl/robot_pkg.sv
// Shared constants and types for the robot input-conditioning logic.
package robot_pkg;

    localparam int CLK_HZ        = 50_000_000;
    localparam int DEBOUNCE_20MS = CLK_HZ / 50;
    localparam int HOLD_500MS    = CLK_HZ / 2;
    localparam int REPEAT_100MS  = CLK_HZ / 10;

    typedef enum logic [1:0] {
        RELEASED,
        HOLD,
        REPEAT
    } key_state_e;

    // Counter width for a modulus, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchroniser, debounce counter, hold/repeat FSM.
module key_channel
    import robot_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
    parameter int HOLD_CYCLES     = HOLD_500MS,
    parameter int REPEAT_CYCLES   = REPEAT_100MS
) (
    input  logic clock_50,
    input  logic reset_key,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_repeat
);

    localparam int DW = cnt_w(DEBOUNCE_CYCLES);
    localparam int TW = cnt_w((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] H_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] R_LAST = TW'(REPEAT_CYCLES - 1);

    logic          sync1, s;
    logic [DW-1:0] dcnt, dcnt_nx;
    logic [TW-1:0] timer, timer_nx;
    key_state_e    state, state_nx;
    logic          level_nx, press_nx, release_nx, repeat_nx;
    logic          differs, commit;

    // s is active-low, key_level is active-high
    assign differs = (~s) != key_level;
    assign commit  = differs && (dcnt == D_LAST);

    always_ff @(posedge clock_50 or negedge reset_key) begin
        if (!reset_key) begin
            sync1       <= 1'b1;
            s           <= 1'b1;
            dcnt        <= '0;
            timer       <= '0;
            state       <= RELEASED;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_repeat  <= 1'b0;
        end else begin
            sync1       <= key_n;
            s           <= sync1;
            dcnt        <= dcnt_nx;
            timer       <= timer_nx;
            state       <= state_nx;
            key_level   <= level_nx;
            key_press   <= press_nx;
            key_release <= release_nx;
            key_repeat  <= repeat_nx;
        end
    end

    always_comb begin
        dcnt_nx    = '0;
        timer_nx   = timer;
        state_nx   = state;
        level_nx   = key_level;
        press_nx   = 1'b0;
        release_nx = 1'b0;
        repeat_nx  = 1'b0;

        if (differs && !commit)
            dcnt_nx = dcnt + 1'b1;

        // A commit takes priority over any timer expiry in the same cycle.
        if (commit && !key_level) begin
            level_nx = 1'b1;
            press_nx = 1'b1;
            state_nx = HOLD;
            timer_nx = '0;
        end else if (commit) begin
            level_nx   = 1'b0;
            release_nx = 1'b1;
            state_nx   = RELEASED;
            timer_nx   = '0;
        end else begin
            case (state)
                HOLD: begin
                    if (timer == H_LAST) begin
                        repeat_nx = 1'b1;
                        state_nx  = REPEAT;
                        timer_nx  = '0;
                    end else begin
                        timer_nx = timer + 1'b1;
                    end
                end
                REPEAT: begin
                    if (timer == R_LAST) begin
                        repeat_nx = 1'b1;
                        timer_nx  = '0;
                    end else begin
                        timer_nx = timer + 1'b1;
                    end
                end
                default: timer_nx = '0;
            endcase
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Debounced, edge- and repeat-pulsed view of the board push-buttons.
module key_conditioner
    import robot_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
    parameter int HOLD_CYCLES     = HOLD_500MS,
    parameter int REPEAT_CYCLES   = REPEAT_100MS
) (
    input  logic              clock_50,
    input  logic              reset_key,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_repeat
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_ch (
            .clock_50   (clock_50),
            .reset_key  (reset_key),
            .key_n      (key_n[i]),
            .key_level  (key_level[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i]),
            .key_repeat (key_repeat[i])
        );
    end

endmodule
